// File: rtl/dpdm_tx_arbiter.sv
// Two-requester transmit scheduler for the DPDM line encoder with start/drain watchdogs.
// Define DPDM_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module dpdm_tx_arbiter #(
   parameter int unsigned IPG      = 4,
   parameter int unsigned START_TO = 16,
   parameter int unsigned DRAIN_TO = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] snd,
   input  logic [1:0] bit_in,
   input  logic       enc_out_done,
   output logic [1:0] gnt,
   output logic       enc_valid,
   output logic       enc_bit,
   output logic [1:0] done,
   output logic       err_start,
   output logic       err_drain,
   output logic       busy
);

   typedef enum logic [2:0] {StIdle, StGrant, StSend, StDrain, StGap} state_t;

   localparam logic [7:0] StartLast = 8'(START_TO - 1);
   localparam logic [7:0] DrainLast = 8'(DRAIN_TO - 1);
   localparam logic [7:0] IpgLast   = 8'(IPG - 1);

   state_t     state_q, state_d;
   logic       w_q, w_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] gnt_d, done_d;
   logic       err_start_d, err_drain_d;
`ifdef DPDM_ARB_RR_EN
   logic       lsp_q, lsp_d;
`endif

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      cnt_d       = cnt_q;
      done_d      = 2'b00;
      err_start_d = 1'b0;
      err_drain_d = 1'b0;
`ifdef DPDM_ARB_RR_EN
      lsp_d       = lsp_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|req) begin
               state_d = StGrant;
               if (req == 2'b11) begin
`ifdef DPDM_ARB_RR_EN
                  w_d = ~lsp_q;
`else
                  w_d = 1'b0;
`endif
               end else begin
                  w_d = req[1];
               end
            end
         end
         StGrant: begin
            if (snd[w_q]) begin
               state_d = StSend;
            end else if (cnt_q == StartLast) begin
               err_start_d = 1'b1;
`ifdef DPDM_ARB_RR_EN
               lsp_d       = w_q;
`endif
               state_d     = StIdle;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StSend: begin
            if (!snd[w_q]) state_d = StDrain;
         end
         StDrain: begin
            // A done pulse on the expiry cycle takes precedence over the watchdog.
            if (enc_out_done) begin
               done_d[w_q] = 1'b1;
`ifdef DPDM_ARB_RR_EN
               lsp_d       = w_q;
`endif
               state_d     = StGap;
            end else if (cnt_q == DrainLast) begin
               err_drain_d = 1'b1;
`ifdef DPDM_ARB_RR_EN
               lsp_d       = w_q;
`endif
               state_d     = StGap;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StGap: begin
            if (cnt_q == IpgLast) state_d = StIdle;
            else                  cnt_d   = cnt_q + 8'd1;
         end
         default: state_d = StIdle;
      endcase

      if (state_d != state_q) cnt_d = 8'd0;

      gnt_d = 2'b00;
      if (state_d == StGrant || state_d == StSend) gnt_d[w_d] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         w_q       <= 1'b0;
         cnt_q     <= 8'd0;
         gnt       <= 2'b00;
         done      <= 2'b00;
         err_start <= 1'b0;
         err_drain <= 1'b0;
`ifdef DPDM_ARB_RR_EN
         lsp_q     <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         w_q       <= w_d;
         cnt_q     <= cnt_d;
         gnt       <= gnt_d;
         done      <= done_d;
         err_start <= err_start_d;
         err_drain <= err_drain_d;
`ifdef DPDM_ARB_RR_EN
         lsp_q     <= lsp_d;
`endif
      end
   end

   // Combinational so the encoder sees the first bit in the cycle it is driven.
   assign enc_valid = (state_q == StGrant || state_q == StSend) && snd[w_q];
   assign enc_bit   = enc_valid & bit_in[w_q];
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dpdm_tx_arbiter.sv
// Scoreboard bench for dpdm_tx_arbiter: stimulus pushes timed expected events,
// a negedge monitor pops and compares them; a few direct timing checks are made inline.
module tb_dpdm_tx_arbiter;

   localparam int IPG      = 4;
   localparam int START_TO = 16;
   localparam int DRAIN_TO = 32;

   localparam int EvGnt  = 0;
   localparam int EvBit  = 1;
   localparam int EvDone = 2;
   localparam int EvErrS = 3;
   localparam int EvErrD = 4;

   typedef struct {
      int         kind;
      logic [1:0] val;
      int         at;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic [1:0] req, snd, bit_in;
   logic       enc_out_done;
   logic [1:0] gnt, done;
   logic       enc_valid, enc_bit, err_start, err_drain, busy;

   int         cyc = 0;
   int         asserts = 0;
   int         fails = 0;
   ev_t        q[$];
   logic [1:0] gnt_prev = 2'b00;
   string      ev_name[5] = '{"gnt", "bit", "done", "err_start", "err_drain"};

   dpdm_tx_arbiter #(
      .IPG      (IPG),
      .START_TO (START_TO),
      .DRAIN_TO (DRAIN_TO)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .snd          (snd),
      .bit_in       (bit_in),
      .enc_out_done (enc_out_done),
      .gnt          (gnt),
      .enc_valid    (enc_valid),
      .enc_bit      (enc_bit),
      .done         (done),
      .err_start    (err_start),
      .err_drain    (err_drain),
      .busy         (busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input int kind, input logic [1:0] val, input int at);
      ev_t e;
      e.kind = kind;
      e.val  = val;
      e.at   = at;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      asserts++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic ev_check(input int kind, input logic [1:0] val);
      ev_t e;
      asserts++;
      if (q.size() == 0) begin
         fails++;
         $display("FAIL ev_%s at cycle %0d: got unexpected value %0h, expected no event",
                  ev_name[kind], cyc, val);
      end else begin
         e = q.pop_front();
         if (e.kind != kind || e.val !== val || e.at != cyc) begin
            fails++;
            $display("FAIL ev_%s at cycle %0d: got %s=%0h, expected %s=%0h at cycle %0d",
                     ev_name[kind], cyc, ev_name[kind], val, ev_name[e.kind], e.val, e.at);
         end
      end
   endtask

   always @(negedge clock) begin
      if (gnt != 2'b00 && gnt_prev == 2'b00) ev_check(EvGnt, gnt);
      if (enc_valid)                         ev_check(EvBit, {1'b0, enc_bit});
      if (done != 2'b00)                     ev_check(EvDone, done);
      if (err_start)                         ev_check(EvErrS, 2'b01);
      if (err_drain)                         ev_check(EvErrD, 2'b01);
      gnt_prev = gnt;
   end

   // One transfer from IDLE. done_off < 0 means no encoder done (drain watchdog expires).
   task automatic xfer(input logic [1:0] req_v, input logic hold, input int w, input int sdelay,
                       input logic [7:0] bits, input int nbits, input int done_off);
      logic [1:0] eg;
      int         k, e;
      eg = (w == 1) ? 2'b10 : 2'b01;
      req = req_v;
      push(EvGnt, eg, cyc + 1);
      tick();
      chk("gnt_rise", {6'd0, gnt}, {6'd0, eg});
      if (!hold) req = 2'b00;
      repeat (sdelay) tick();
      for (int i = 0; i < nbits; i++) begin
         snd[w]       = 1'b1;
         bit_in[w]    = bits[i];
         snd[1-w]     = (i % 2 == 1);
         bit_in[1-w]  = ~bits[i];
         push(EvBit, {1'b0, bits[i]}, cyc);
         tick();
      end
      snd    = 2'b00;
      bit_in = 2'b00;
      k = cyc;
      chk("gnt_last_send", {6'd0, gnt}, {6'd0, eg});
      tick();
      chk("gnt_drop", {6'd0, gnt}, 8'd0);
      chk("busy_drain", {7'd0, busy}, 8'd1);
      if (done_off >= 1) begin
         repeat (done_off - 1) tick();
         e = k + done_off + 1;
         enc_out_done = 1'b1;
         push(EvDone, eg, e);
         tick();
         enc_out_done = 1'b0;
      end else begin
         e = k + 1 + DRAIN_TO;
         push(EvErrD, 2'b01, e);
      end
      while (cyc < e + IPG - 1) tick();
      chk("busy_gap", {7'd0, busy}, 8'd1);
      tick();
      chk("busy_idle", {7'd0, busy}, 8'd0);
   endtask

   initial begin
      int c;
      reset = 1'b1; req = 2'b00; snd = 2'b00; bit_in = 2'b00; enc_out_done = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_gnt", {6'd0, gnt}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_done", {6'd0, done}, 8'd0);
      chk("rst_errs", {6'd0, err_start, err_drain}, 8'd0);
      chk("rst_enc", {6'd0, enc_valid, enc_bit}, 8'd0);
      tick();

      // Tie with both requests held.
`ifdef DPDM_ARB_RR_EN
      xfer(2'b11, 1'b1, 0, 0, 8'hA5, 4, 2);
      xfer(2'b11, 1'b1, 1, 0, 8'h3C, 4, 2);
      xfer(2'b11, 1'b1, 0, 0, 8'h96, 4, 2);
`else
      xfer(2'b11, 1'b1, 0, 0, 8'hA5, 4, 2);
      xfer(2'b11, 1'b1, 0, 0, 8'h3C, 4, 2);
      xfer(2'b11, 1'b1, 0, 0, 8'h96, 4, 2);
`endif
      req = 2'b00;
      tick();

      // Single request, one idle GRANT cycle, eight bits, done ten cycles after snd drops.
      xfer(2'b01, 1'b0, 0, 1, 8'b1011_0010, 8, 10);

      // Start timeout on requester 1.
      c = cyc;
      req = 2'b10;
      push(EvGnt, 2'b10, c + 1);
      push(EvErrS, 2'b01, c + 1 + START_TO);
      tick();
      req = 2'b00;
      while (cyc < c + START_TO) tick();
      chk("start_gnt_hold", {6'd0, gnt}, 8'h02);
      tick();
      chk("start_gnt_fall", {6'd0, gnt}, 8'd0);
      chk("start_busy", {7'd0, busy}, 8'd0);
      tick();

      // Drain timeout, then done coinciding with the watchdog expiry.
      xfer(2'b01, 1'b0, 0, 0, 8'h5A, 6, -1);
      xfer(2'b10, 1'b0, 1, 0, 8'hC3, 5, DRAIN_TO);

      // Stray done in IDLE must be ignored.
      enc_out_done = 1'b1;
      tick();
      enc_out_done = 1'b0;
      tick();
      chk("stray_done", {6'd0, done}, 8'd0);
      chk("stray_busy", {7'd0, busy}, 8'd0);

      xfer(2'b01, 1'b0, 0, 0, 8'h0F, 3, 3);

      // Reset while sending on requester 0.
      c = cyc;
      req = 2'b01;
      push(EvGnt, 2'b01, c + 1);
      tick();
      req = 2'b00;
      for (int i = 0; i < 4; i++) begin
         snd[0]    = 1'b1;
         bit_in[0] = (i % 2 == 0);
         push(EvBit, {1'b0, (i % 2 == 0)}, cyc);
         if (i == 3) reset = 1'b1;
         tick();
      end
      reset = 1'b0;
      chk("mid_rst_gnt", {6'd0, gnt}, 8'd0);
      chk("mid_rst_valid", {7'd0, enc_valid}, 8'd0);
      chk("mid_rst_busy", {7'd0, busy}, 8'd0);
      snd    = 2'b00;
      bit_in = 2'b00;
      tick();

      // Restart after reset: tie resolves to requester 0 in both builds.
      xfer(2'b11, 1'b1, 0, 0, 8'hE7, 4, 2);
      req = 2'b00;
      repeat (4) tick();

      asserts++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending events, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
